// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: microword field positions,
// COND encodings, FSM state encoding and the reset microstore address.
package micro_sequencer_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned WORD_W  = 41;
    localparam int unsigned IR_W    = 32;
    localparam int unsigned FLAGS_W = 4;

    // Microword field bit positions
    localparam int unsigned A_HI     = 40;
    localparam int unsigned A_LO     = 35;
    localparam int unsigned AMUX_BIT = 34;
    localparam int unsigned B_HI     = 33;
    localparam int unsigned B_LO     = 28;
    localparam int unsigned BMUX_BIT = 27;
    localparam int unsigned C_HI     = 26;
    localparam int unsigned C_LO     = 21;
    localparam int unsigned RDWR_HI  = 20;
    localparam int unsigned RDWR_LO  = 18;
    localparam int unsigned RD_BIT   = 19;
    localparam int unsigned WR_BIT   = 18;
    localparam int unsigned ALU_HI   = 17;
    localparam int unsigned ALU_LO   = 14;
    localparam int unsigned COND_HI  = 13;
    localparam int unsigned COND_LO  = 11;
    localparam int unsigned JADDR_HI = 10;
    localparam int unsigned JADDR_LO = 0;

    // Condition-code positions within {n,z,v,c}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    // IR bit tested by COND_IR13
    localparam int unsigned IR_TEST_BIT = 13;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXEC    = 2'b01,
        ST_MEMWAIT = 2'b10
    } state_e;

    localparam logic [ADDR_W-1:0] RESET_ADDR = '0;

endpackage

// File: rtl/mseq_next_addr.sv
// Combinational next-microaddress selection.
// Ports: csai (current address), cond/jaddr (from MIR), flags {n,z,v,c},
//        ir (instruction register), next_addr_c (selected next address).
module mseq_next_addr
    import micro_sequencer_pkg::*;
(
    input  logic [ADDR_W-1:0]  csai,
    input  cond_e              cond,
    input  logic [ADDR_W-1:0]  jaddr,
    input  logic [FLAGS_W-1:0] flags,
    input  logic [IR_W-1:0]    ir,
    output logic [ADDR_W-1:0]  next_addr_c
);

    logic [ADDR_W-1:0] incr_c;
    logic [ADDR_W-1:0] decode_c;
    logic              unused_ir_bits;

    // Only the opcode-class and op3 fields of IR steer decode
    assign unused_ir_bits = ^{ir[29:25], ir[18:14], ir[12:0]};

    // Increment wraps naturally at the address width
    assign incr_c   = csai + ADDR_W'(1);
    assign decode_c = {1'b1, ir[31:30], ir[24:19], 2'b00};

    // COND mux: untaken conditionals fall through to csai+1
    always_comb begin
        next_addr_c = incr_c;
        case (cond)
            COND_NEXT:   next_addr_c = incr_c;
            COND_N:      if (flags[FLAG_N])   next_addr_c = jaddr;
            COND_Z:      if (flags[FLAG_Z])   next_addr_c = jaddr;
            COND_V:      if (flags[FLAG_V])   next_addr_c = jaddr;
            COND_C:      if (flags[FLAG_C])   next_addr_c = jaddr;
            COND_IR13:   if (ir[IR_TEST_BIT]) next_addr_c = jaddr;
            COND_JUMP:   next_addr_c = jaddr;
            COND_DECODE: next_addr_c = decode_c;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches microwords from a combinational control
// ROM into the MIR, issues memory strobes and stalls until acknowledged.
// Ports: CLOCK_50/RESET_InHigh, ROM address/data, MIR out, IR and flags in,
//        memory read/write strobes, memory ack, stall.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int unsigned MSEQ_ADDR_W = 11,
    parameter int unsigned MSEQ_WORD_W = 41
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_InHigh,
    output logic [MSEQ_ADDR_W-1:0] MSEQ_ROMAddr_Out,
    input  logic [MSEQ_WORD_W-1:0] MSEQ_ROMData_In,
    output logic [MSEQ_WORD_W-1:0] MSEQ_MIR_Out,
    input  logic [IR_W-1:0]        MSEQ_IR_In,
    input  logic [FLAGS_W-1:0]     MSEQ_Flags_In,
    output logic                   MSEQ_MemRd_Out,
    output logic                   MSEQ_MemWr_Out,
    input  logic                   MSEQ_MemAck_In,
    output logic                   MSEQ_Stall_Out
);

    state_e                 state;
    logic [MSEQ_ADDR_W-1:0] csai;
    logic [MSEQ_WORD_W-1:0] mir;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   stall;
    logic [ADDR_W-1:0]      next_addr_c;
    logic                   rd_req_c;
    logic                   wr_req_c;

    // Read wins when both request bits are set
    assign rd_req_c = mir[RD_BIT];
    assign wr_req_c = mir[WR_BIT] & ~mir[RD_BIT];

    mseq_next_addr u_next_addr (
        .csai        (ADDR_W'(csai)),
        .cond        (cond_e'(mir[COND_HI:COND_LO])),
        .jaddr       (mir[JADDR_HI:JADDR_LO]),
        .flags       (MSEQ_Flags_In),
        .ir          (MSEQ_IR_In),
        .next_addr_c (next_addr_c)
    );

    // Sequencer FSM; next address committed at end of EXEC or on ack
    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state  <= ST_FETCH;
            csai   <= MSEQ_ADDR_W'(RESET_ADDR);
            mir    <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            stall  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    mir   <= MSEQ_ROMData_In;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (rd_req_c || wr_req_c) begin
                        mem_rd <= rd_req_c;
                        mem_wr <= wr_req_c;
                        stall  <= 1'b1;
                        state  <= ST_MEMWAIT;
                    end else begin
                        csai  <= MSEQ_ADDR_W'(next_addr_c);
                        state <= ST_FETCH;
                    end
                end
                ST_MEMWAIT: begin
                    if (MSEQ_MemAck_In) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        stall  <= 1'b0;
                        csai   <= MSEQ_ADDR_W'(next_addr_c);
                        state  <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign MSEQ_ROMAddr_Out = csai;
    assign MSEQ_MIR_Out     = mir;
    assign MSEQ_MemRd_Out   = mem_rd;
    assign MSEQ_MemWr_Out   = mem_wr;
    assign MSEQ_Stall_Out   = stall;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a behavioural model expands a microprogram into
// the expected per-cycle output trace, which is checked cycle by cycle.
module tb_micro_sequencer;

    typedef struct packed {
        logic [10:0] addr;
        logic [40:0] mir;
        logic        rd;
        logic        wr;
        logic        stall;
        logic        ack;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [10:0] rom_addr;
    logic [40:0] rom_data;
    logic [40:0] mir_out;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic        mem_rd;
    logic        mem_wr;
    logic        ack;
    logic        stall;

    logic [40:0] rom [0:2047];
    ent_t        tr [$];
    int          waits [$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          cnt_rd, cnt_wr, cnt_stall;

    assign rom_data = rom[rom_addr];

    micro_sequencer dut (
        .CLOCK_50         (clk),
        .RESET_InHigh     (rst),
        .MSEQ_ROMAddr_Out (rom_addr),
        .MSEQ_ROMData_In  (rom_data),
        .MSEQ_MIR_Out     (mir_out),
        .MSEQ_IR_In       (ir),
        .MSEQ_Flags_In    (flags),
        .MSEQ_MemRd_Out   (mem_rd),
        .MSEQ_MemWr_Out   (mem_wr),
        .MSEQ_MemAck_In   (ack),
        .MSEQ_Stall_Out   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [40:0] mk_word(input logic [2:0] rdwr, input logic [2:0] cond,
                                            input logic [10:0] jaddr);
        return {6'h2A, 1'b1, 6'h15, 1'b0, 6'h33, rdwr, 4'h9, cond, jaddr};
    endfunction

    // Next-address rule, stated arithmetically from the COND table
    function automatic logic [10:0] model_next(input logic [40:0] w, input logic [10:0] pc);
        int inc, j, dec;
        logic taken;
        inc = (int'(pc) + 1) % 2048;
        j   = int'(w[10:0]);
        dec = 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
        case (w[13:11])
            3'd0: taken = 1'b0;
            3'd1: taken = flags[3];
            3'd2: taken = flags[2];
            3'd3: taken = flags[1];
            3'd4: taken = flags[0];
            3'd5: taken = ir[13];
            3'd6: taken = 1'b1;
            default: return 11'(dec);
        endcase
        return taken ? 11'(j) : 11'(inc);
    endfunction

    // Expand n microinstructions from reset into the expected cycle trace;
    // bit k of stray asserts a spurious ack in instruction k's fetch and exec
    task automatic build_trace(input int n, input int stray);
        logic [10:0] pc;
        logic [40:0] prev, w;
        logic        rd, wr;
        int          wt;
        ent_t        e;
        pc = 11'h000;
        prev = '0;
        tr.delete();
        for (int k = 0; k < n; k++) begin
            w = rom[pc];
            e = '{addr: pc, mir: prev, rd: 1'b0, wr: 1'b0, stall: 1'b0, ack: stray[k]};
            tr.push_back(e);
            e.mir = w;
            tr.push_back(e);
            if (w[19] || w[18]) begin
                rd = w[19];
                wr = w[18] && !w[19];
                wt = (waits.size() > 0) ? waits.pop_front() : 1;
                for (int j = 0; j < wt; j++) begin
                    e = '{addr: pc, mir: w, rd: rd, wr: wr, stall: 1'b1, ack: (j == wt - 1)};
                    tr.push_back(e);
                end
            end
            pc = model_next(w, pc);
            prev = w;
        end
    endtask

    // Walk the trace from a falling edge, one cycle per entry
    task automatic run_trace(input string tag);
        ent_t e;
        int   cyc;
        cnt_rd = 0; cnt_wr = 0; cnt_stall = 0; cyc = 0;
        while (tr.size() > 0) begin
            e = tr.pop_front();
            #1;
            n_total++;
            if (rom_addr !== e.addr || mir_out !== e.mir || mem_rd !== e.rd ||
                mem_wr !== e.wr || stall !== e.stall) begin
                n_bad++;
                $display("FAIL %s cyc%0d (act/exp) addr=%h/%h mir=%h/%h rd=%b/%b wr=%b/%b stall=%b/%b",
                         tag, cyc, rom_addr, e.addr, mir_out, e.mir, mem_rd, e.rd,
                         mem_wr, e.wr, stall, e.stall);
            end
            cnt_rd    += int'(mem_rd);
            cnt_wr    += int'(mem_wr);
            cnt_stall += int'(stall);
            ack = e.ack;
            cyc++;
            @(negedge clk);
        end
        ack = 1'b0;
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        waits.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ack = 1'b0;
        #1;
        check("reset_state", {rom_addr, mir_out, mem_rd, mem_wr, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; ir = '0; flags = '0;
        clear_rom();

        // Straight-line sequence 0,1,2
        rom[0] = mk_word(3'b000, 3'b000, 11'h123);
        rom[1] = mk_word(3'b000, 3'b000, 11'h456);
        rom[2] = mk_word(3'b000, 3'b000, 11'h789);
        do_reset();
        build_trace(3, 0);
        run_trace("seq");
        check("seq_end_addr", 64'(rom_addr), 64'(11'd3));

        // Decode dispatch
        clear_rom();
        ir = 32'hC020_0000;
        rom[0] = mk_word(3'b000, 3'b111, 11'h000);
        rom[11'h710] = mk_word(3'b000, 3'b000, 11'h001);
        do_reset();
        build_trace(2, 0);
        run_trace("decode");
        check("decode_pin", 64'(model_next(rom[0], 11'h000)), 64'(11'b11100010000));
        check("decode_after", 64'(rom_addr), 64'(11'h711));

        // Conditional branches, taken and untaken, other flags set when untaken
        for (int c = 1; c <= 5; c++) begin
            for (int t = 0; t < 2; t++) begin
                clear_rom();
                if (c == 5) begin
                    flags = 4'hF;
                    ir = (t == 1) ? 32'h0000_2000 : 32'hFFFF_DFFF;
                end else begin
                    flags = 4'(1 << (4 - c));
                    if (t == 0) flags = ~flags;
                    ir = 32'h0;
                end
                rom[0] = mk_word(3'b000, 3'(c), 11'h155);
                do_reset();
                build_trace(1, 0);
                run_trace($sformatf("cond%0d_t%0d", c, t));
                check($sformatf("cond%0d_t%0d_addr", c, t), 64'(rom_addr),
                      (t == 1) ? 64'(11'h155) : 64'(11'h001));
            end
        end
        flags = '0; ir = '0;

        // Read with three wait cycles
        clear_rom();
        rom[0] = mk_word(3'b010, 3'b000, 11'h000);
        waits.push_back(3);
        do_reset();
        build_trace(1, 0);
        run_trace("read3");
        check("read3_rd_cycles", 64'(cnt_rd), 64'd3);
        check("read3_stall_cycles", 64'(cnt_stall), 64'd3);
        check("read3_addr", 64'(rom_addr), 64'(11'h001));

        // Write, read+write priority, jump, with stray acks outside MEMWAIT
        clear_rom();
        rom[0] = mk_word(3'b001, 3'b000, 11'h000);
        rom[1] = mk_word(3'b011, 3'b110, 11'h040);
        rom[11'h040] = mk_word(3'b000, 3'b000, 11'h000);
        waits.push_back(1);
        waits.push_back(2);
        do_reset();
        build_trace(3, 5);
        run_trace("memmix");
        check("memmix_wr_cycles", 64'(cnt_wr), 64'd1);
        check("memmix_rd_cycles", 64'(cnt_rd), 64'd2);
        check("memmix_addr", 64'(rom_addr), 64'(11'h041));

        // Wrap from 0x7FF to 0x000
        clear_rom();
        rom[0] = mk_word(3'b000, 3'b110, 11'h7FF);
        rom[11'h7FF] = mk_word(3'b000, 3'b000, 11'h2AA);
        do_reset();
        build_trace(2, 0);
        run_trace("wrap");
        check("wrap_addr", 64'(rom_addr), 64'(11'h000));

        // Reset during MEMWAIT aborts the request; later ack ignored
        clear_rom();
        rom[0] = mk_word(3'b010, 3'b000, 11'h000);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_rd_before", 64'({mem_rd, stall}), 64'(2'b11));
        rst = 1'b1;
        #1;
        check("abort_async", {rom_addr, mir_out, mem_rd, mem_wr, stall}, 64'd0);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waits.push_back(2);
        build_trace(1, 1);
        run_trace("abort_resume");
        check("abort_resume_addr", 64'(rom_addr), 64'(11'h001));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
